// File: rtl/camera_pkg.sv
// Shared frame geometry, datapath widths and centroid FSM state type for the
// camera pipeline.
package camera_pkg;

  localparam int unsigned H_ACTIVE = 320;
  localparam int unsigned V_ACTIVE = 240;

  localparam int unsigned SUM_W = 25;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } centroid_state_t;

endpackage

// File: rtl/serial_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle, MSB first.
// The first bit is produced on the start cycle itself; done pulses once after the last bit.
module serial_divider #(
  parameter int unsigned DVD_W = 25,
  parameter int unsigned DVS_W = 17,
  parameter int unsigned QUO_W = DVD_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QUO_W-1:0] quotient
);

  localparam int unsigned IT_W = $clog2(DVD_W + 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [QUO_W-1:0] quo_q, quo_d;

  logic [DVD_W-1:0] src_dvd;
  logic [DVS_W-1:0] src_dvs;
  logic [DVS_W-1:0] src_rem;
  logic [QUO_W-1:0] src_quo;
  logic [DVS_W:0]   trial;
  logic             fits;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    iter_d = iter_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;

    src_dvd = start ? dividend : dvd_q;
    src_dvs = start ? divisor  : dvs_q;
    src_rem = start ? '0       : rem_q;
    src_quo = start ? '0       : quo_q;
    trial   = {src_rem, src_dvd[DVD_W-1]};
    fits    = (trial >= {1'b0, src_dvs});

    if (start || busy_q) begin
      dvd_d = {src_dvd[DVD_W-2:0], 1'b0};
      dvs_d = src_dvs;
      rem_d = fits ? DVS_W'(trial - {1'b0, src_dvs}) : trial[DVS_W-1:0];
      // Quotient register only keeps the low QUO_W bits; higher bits shift out.
      quo_d = {src_quo[QUO_W-2:0], fits};
      if (start) begin
        iter_d = IT_W'(1);
        busy_d = 1'b1;
      end else begin
        iter_d = iter_q + IT_W'(1);
        if (iter_q == IT_W'(DVD_W - 1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      iter_q <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      iter_q <= iter_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/spot_centroid.sv
// Per-frame centroid of bright pixels: accumulates coordinate sums from the
// pixel stream and divides them by the bright-pixel count at frame end.
module spot_centroid
  import camera_pkg::*;
#(
  parameter int unsigned H_ACTIVE = camera_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = camera_pkg::V_ACTIVE,
  parameter logic [3:0]  THRESH   = 4'd10
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [11:0]      pixel_in,
  input  logic             pixel_valid_in,
  input  logic             frame_done_in,
  output logic [X_W-1:0]   centroid_x_out,
  output logic [Y_W-1:0]   centroid_y_out,
  output logic [CNT_W-1:0] count_out,
  output logic             spot_found_out,
  output logic             centroid_valid_out,
  output logic             busy_out
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  logic [X_W-1:0]   x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]   y_cnt_q, y_cnt_d;
  logic [SUM_W-1:0] sum_x_q, sum_x_d;
  logic [SUM_W-1:0] sum_y_q, sum_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] snap_cnt_q, snap_cnt_d;

  centroid_state_t  state_q, state_d;

  logic [X_W-1:0]   cx_q, cx_d;
  logic [Y_W-1:0]   cy_q, cy_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             found_q, found_d;
  logic             valid_q, valid_d;

  logic             bright;
  logic             div_start;
  logic             div_x_busy, div_y_busy;
  logic             div_x_done, div_y_done;
  logic [X_W-1:0]   quo_x;
  logic [Y_W-1:0]   quo_y;

  assign bright = (pixel_in[11:8] > THRESH) &&
                  (pixel_in[7:4]  > THRESH) &&
                  (pixel_in[3:0]  > THRESH);

  // Accumulation never stalls: frame end clears and drops any coincident pixel.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (frame_done_in) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (pixel_valid_in) begin
      if (bright) begin
        sum_x_d = sum_x_q + SUM_W'(x_cnt_q);
        sum_y_d = sum_y_q + SUM_W'(y_cnt_q);
        cnt_d   = cnt_q + CNT_W'(1);
      end
      if (x_cnt_q == X_LAST) begin
        x_cnt_d = '0;
        y_cnt_d = (y_cnt_q == Y_LAST) ? '0 : y_cnt_q + Y_W'(1);
      end else begin
        x_cnt_d = x_cnt_q + X_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_cnt_d = snap_cnt_q;
    div_start  = 1'b0;
    cx_d       = cx_q;
    cy_d       = cy_q;
    count_d    = count_q;
    found_d    = found_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_done_in) begin
          if (cnt_q != '0) begin
            div_start  = 1'b1;
            snap_cnt_d = cnt_q;
            state_d    = DIV;
          end else begin
            cx_d    = '0;
            cy_d    = '0;
            count_d = '0;
            found_d = 1'b0;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DIV: begin
        if (div_x_done && div_y_done) begin
          cx_d    = quo_x;
          cy_d    = quo_y;
          count_d = snap_cnt_q;
          found_d = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      cnt_q      <= '0;
      snap_cnt_q <= '0;
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      count_q    <= '0;
      found_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      x_cnt_q    <= x_cnt_d;
      y_cnt_q    <= y_cnt_d;
      sum_x_q    <= sum_x_d;
      sum_y_q    <= sum_y_d;
      cnt_q      <= cnt_d;
      snap_cnt_q <= snap_cnt_d;
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      count_q    <= count_d;
      found_q    <= found_d;
      valid_q    <= valid_d;
    end
  end

  serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .QUO_W (X_W)
  ) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (sum_x_q),
    .divisor  (cnt_q),
    .busy     (div_x_busy),
    .done     (div_x_done),
    .quotient (quo_x)
  );

  serial_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W),
    .QUO_W (Y_W)
  ) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (div_start),
    .dividend (sum_y_q),
    .divisor  (cnt_q),
    .busy     (div_y_busy),
    .done     (div_y_done),
    .quotient (quo_y)
  );

  assign centroid_x_out     = cx_q;
  assign centroid_y_out     = cy_q;
  assign count_out          = count_q;
  assign spot_found_out     = found_q;
  assign centroid_valid_out = valid_q;
  assign busy_out           = (state_q == DIV) || div_x_busy || div_y_busy;

endmodule

// File: tb/tb_spot_centroid.sv
// Directed bench for spot_centroid: table of partial frames with hand-computed
// centroids, plus sequences for frame end during division and mid-division reset.
module tb_spot_centroid;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [11:0] pixel_in;
  logic        pixel_valid_in;
  logic        frame_done_in;
  logic [8:0]  centroid_x_out;
  logic [7:0]  centroid_y_out;
  logic [16:0] count_out;
  logic        spot_found_out;
  logic        centroid_valid_out;
  logic        busy_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  spot_centroid #(
    .H_ACTIVE (320),
    .V_ACTIVE (240),
    .THRESH   (4'd10)
  ) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .pixel_in           (pixel_in),
    .pixel_valid_in     (pixel_valid_in),
    .frame_done_in      (frame_done_in),
    .centroid_x_out     (centroid_x_out),
    .centroid_y_out     (centroid_y_out),
    .count_out          (count_out),
    .spot_found_out     (spot_found_out),
    .centroid_valid_out (centroid_valid_out),
    .busy_out           (busy_out)
  );

  typedef struct {
    string       name;
    int          npix;
    int          rx, ry, rw, rh;
    logic [11:0] fg, bg;
    int          gap;
    int          ex, ey, ec, ef, elat, ebusy;
  } vec_t;

  vec_t vecs[5];

  function automatic vec_t mk(input string name, input int npix, input int rx, input int ry,
                              input int rw, input int rh, input logic [11:0] fg,
                              input logic [11:0] bg, input int gap, input int ex,
                              input int ey, input int ec, input int ef, input int elat,
                              input int ebusy);
    vec_t v;
    v.name = name; v.npix = npix; v.rx = rx; v.ry = ry; v.rw = rw; v.rh = rh;
    v.fg = fg; v.bg = bg; v.gap = gap; v.ex = ex; v.ey = ey; v.ec = ec; v.ef = ef;
    v.elat = elat; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Streams npix pixels in raster order from (0,0), then raises frame_done_in
  // so that it is sampled on the next rising edge.
  task automatic feed_frame(input vec_t v);
    for (int i = 0; i < v.npix; i++) begin
      int px;
      int py;
      px = i % 320;
      py = i / 320;
      @(negedge clk_in);
      pixel_valid_in = 1'b1;
      pixel_in = (px >= v.rx && px < v.rx + v.rw && py >= v.ry && py < v.ry + v.rh) ? v.fg : v.bg;
      if (v.gap != 0) begin
        @(negedge clk_in);
        pixel_valid_in = 1'b0;
        pixel_in = 12'h000;
      end
    end
    @(negedge clk_in);
    pixel_valid_in = 1'b0;
    pixel_in = 12'h000;
    frame_done_in = 1'b1;
  endtask

  // Watches 45 cycles after the frame_done edge. fd_at/rst_at inject a second
  // frame end or a reset sampled at edge T+fd_at / T+rst_at; with fd_at set,
  // bright pixels are also fed during the division.
  task automatic await_result(input string name, input int ex, input int ey, input int ec,
                              input int ef, input int elat, input int ebusy,
                              input int fd_at, input int rst_at);
    int pulses = 0;
    int lat = 0;
    int busy_n = 0;
    int vx = 0, vy = 0, vc = 0, vf = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk_in);
      #1;
      if (busy_out) busy_n++;
      if (centroid_valid_out) begin
        pulses++;
        if (pulses == 1) begin
          lat = k;
          vx = int'(centroid_x_out);
          vy = int'(centroid_y_out);
          vc = int'(count_out);
          vf = int'(spot_found_out);
        end
      end
      @(negedge clk_in);
      frame_done_in  = (k == fd_at);
      rst_in         = (k == rst_at);
      pixel_valid_in = (fd_at != 0 && k >= 2 && k <= 6);
      pixel_in       = pixel_valid_in ? 12'hFFF : 12'h000;
    end
    chk({name, " pulses"}, pulses, (elat != 0) ? 1 : 0);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy_cycles"}, busy_n, ebusy);
    if (pulses > 0) begin
      chk({name, " x"}, vx, ex);
      chk({name, " y"}, vy, ey);
      chk({name, " count"}, vc, ec);
      chk({name, " found"}, vf, ef);
    end
    chk({name, " hold_x"}, int'(centroid_x_out), ex);
    chk({name, " hold_y"}, int'(centroid_y_out), ey);
    chk({name, " hold_count"}, int'(count_out), ec);
    chk({name, " hold_found"}, int'(spot_found_out), ef);
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk("single", 5*320+11, 10, 5, 1, 1, 12'hFFF, 12'h000, 1, 10, 5, 1, 1, 26, 25);
    vecs[1] = mk("block2x2", 51*320+102, 100, 50, 2, 2, 12'hFFF, 12'h000, 0, 100, 50, 4, 1, 26, 25);
    vecs[2] = mk("empty", 50, 0, 0, 0, 0, 12'hFFF, 12'h000, 1, 0, 0, 0, 0, 1, 0);
    vecs[3] = mk("thresh", 30, 0, 0, 10, 1, 12'hBBB, 12'hAFF, 1, 4, 0, 10, 1, 26, 25);
    vecs[4] = mk("lineend", 4*320, 316, 2, 4, 2, 12'hCDE, 12'h555, 0, 317, 2, 8, 1, 26, 25);

    rst_in = 1'b1;
    pixel_in = 12'h000;
    pixel_valid_in = 1'b0;
    frame_done_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset x", int'(centroid_x_out), 0);
    chk("reset y", int'(centroid_y_out), 0);
    chk("reset count", int'(count_out), 0);
    chk("reset found", int'(spot_found_out), 0);
    chk("reset valid", int'(centroid_valid_out), 0);
    chk("reset busy", int'(busy_out), 0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 5; i++) begin
      feed_frame(vecs[i]);
      await_result(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].ec, vecs[i].ef,
                   vecs[i].elat, vecs[i].ebusy, 0, 0);
    end

    // Second frame end at T+10 while dividing: first result stands, second frame dropped.
    v = mk("fd_in_div", 1*320+3, 2, 1, 1, 1, 12'hFFF, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    feed_frame(v);
    await_result("fd_in_div", 2, 1, 1, 1, 26, 25, 10, 0);

    // Following frame must start from (0,0) with empty sums.
    v = mk("after_fd", 6, 5, 0, 1, 1, 12'hFFF, 12'h000, 1, 0, 0, 0, 0, 0, 0);
    feed_frame(v);
    await_result("after_fd", 5, 0, 1, 1, 26, 25, 0, 0);

    // Reset at T+12 aborts the division; no pulse, outputs cleared.
    v = mk("rst_in_div", 3*320+21, 20, 3, 1, 1, 12'hFFF, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    feed_frame(v);
    await_result("rst_in_div", 0, 0, 0, 0, 0, 12, 0, 12);

    v = mk("after_rst", 7*320+4, 3, 7, 1, 1, 12'hFFF, 12'h000, 0, 0, 0, 0, 0, 0, 0);
    feed_frame(v);
    await_result("after_rst", 3, 7, 1, 1, 26, 25, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
